key_run_ctrl: RTL and testbench
===============================

Name: key_run_ctrl

Overview:
Upstream control stage for the 4-LED running-light block. It synchronises and debounces the raw active-low push button, then produces a one-cycle press pulse. Each debounced press toggles a run-enable level, `vaild`, which directly drives the running-light block's `vaild` input. An optional auto-off timer drops `vaild` after a fixed run time.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised samples needed to accept a press or release (20 ms at 50 MHz); must be >= 1
AUTO_OFF_CYCLES, 0, cycles `vaild` stays high before forced clear; 0 disables auto-off
CNT_W, 24, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
RUN_W, 32, auto-off counter width; must satisfy 2^RUN_W > AUTO_OFF_CYCLES

Ports:
sys_clk    input   1  system clock, 50 MHz
rst_n      input   1  asynchronous active-low reset
key_n      input   1  raw push button, active-low, asynchronous to sys_clk
key_level  output  1  debounced key state, 1 = pressed
key_pulse  output  1  one-cycle pulse on each accepted press
vaild      output  1  run enable to the LED block; toggles per press

Behaviour:
- Interface: single clock `sys_clk`. Reset `rst_n` is asynchronous and active-low, and all flops use it.
- Reset values:
  - key_level = 0, key_pulse = 0, vaild = 0.
  - Both synchroniser flops = 1 (released).
  - FSM = IDLE; debounce and run counters = 0.
- Synchroniser: key_n passes through 2 flops to give key_s. Edge 0 is the first edge sampling key_n low; key_s = 0 after edge 1.
- FSM states:
  - IDLE:
    - key_s == 0 -> PRESS_WAIT, cnt <= 0.
  - PRESS_WAIT:
    - key_s == 1 -> IDLE (bounce rejected, no pulse).
    - Otherwise, if cnt == DEBOUNCE_CYCLES-1 -> PRESSED, key_pulse <= 1.
    - Otherwise cnt <= cnt+1.
  - PRESSED:
    - key_s == 1 -> RELEASE_WAIT, cnt <= 0.
  - RELEASE_WAIT:
    - key_s == 0 -> PRESSED (no new pulse).
    - Otherwise, if cnt == DEBOUNCE_CYCLES-1 -> IDLE.
    - Otherwise cnt <= cnt+1.
- Press latency: for key_n held low, key_pulse and key_level rise at edge DEBOUNCE_CYCLES+2. key_pulse is high for exactly one cycle.
- Release latency: key_level falls at edge DEBOUNCE_CYCLES+2 after the first edge sampling key_n high.
- key_level is 1 in PRESSED and RELEASE_WAIT, and 0 otherwise.
- Key held indefinitely: exactly one pulse; no auto-repeat.
- vaild: on the edge where key_pulse is set, vaild <= ~vaild (registered, same edge).
- Auto-off, when AUTO_OFF_CYCLES > 0:
  - run_cnt increments each cycle while vaild == 1.
  - When run_cnt == AUTO_OFF_CYCLES-1, vaild <= 0 and run_cnt <= 0.
  - run_cnt is held at 0 while vaild == 0.
  - vaild is therefore high for exactly AUTO_OFF_CYCLES cycles.
- Simultaneous press and timeout: vaild <= 0 and run_cnt <= 0.
- Press while vaild == 1: vaild <= 0, run_cnt <= 0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous assert). If the key is still held when reset releases, it is treated as a new press once the debounce completes.
- Counter bounds: the debounce counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Decomposition:
- Shared package key_pkg:
  - FSM state localparams (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3).
  - Default constants: CLK_FREQ_HZ = 50_000_000, DEBOUNCE_20MS = 1_000_000.
- Sub-module key_debounce: synchroniser, FSM and debounce counter. Outputs key_level and key_pulse.
- Top key_run_ctrl: instantiates key_debounce and holds the vaild toggle and auto-off logic.

Test Plan:
All tests use DEBOUNCE_CYCLES=4 and AUTO_OFF_CYCLES=0 unless noted.
- Reset: rst_n=0 with key_n toggling -> key_level=0, key_pulse=0, vaild=0 throughout. After rst_n=1 with key_n=1 -> outputs stay 0.
- Clean press: key_n low from edge 0 for 12 cycles, then high -> key_pulse=1 only in the cycle after edge 6. key_level and vaild go 0->1 at edge 6. key_level returns to 0 at edge 6 after release; vaild stays 1.
- Bounce rejection:
  - key_n low 3 cycles, high 1, low 2, high -> no key_pulse, vaild stays 0.
  - Release bounce (high 2 cycles mid-hold) -> no second pulse.
- Second press: a repeat of the clean press while vaild=1 -> vaild 1->0 on that press's pulse edge; exactly 2 pulses total.
- Auto-off, AUTO_OFF_CYCLES=20: a press sets vaild at edge 6, vaild returns to 0 at edge 26 (20 cycles high). A key held past the timeout does not re-raise vaild.
- Reset mid-debounce: rst_n=0 pulse at edge 4 of a press -> no pulse and vaild=0. With the key still held after reset, a new pulse arrives DEBOUNCE_CYCLES+2 edges after reset release and vaild=1.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the push-button run-control slice: debounce FSM
// state encoding and default timing constants for a 50 MHz system clock.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int CLK_FREQ_HZ   = 50_000_000;
    localparam int DEBOUNCE_20MS = 1_000_000;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debounce FSM for an active-low push button.
// Produces a debounced level, a one-cycle press pulse, and the raw accept strobe.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int CNT_W           = 24
)(
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_pulse,
    output logic press_accept
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_meta;
    logic             key_s;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Synchroniser flops idle high so a reset looks like a released key.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_s    <= key_meta;
        end
    end

    // Same-cycle strobe lets the run-enable toggle on the edge that raises key_pulse.
    assign press_accept = (state == PRESS_WAIT) && !key_s && (cnt == CNT_LAST);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            key_level <= 1'b0;
            key_pulse <= 1'b0;
        end else begin
            key_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        key_pulse <= 1'b1;
                        key_level <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (key_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_s) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        key_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_run_ctrl.sv
// Run-enable control for the running-light block: each debounced press toggles
// vaild, and an optional timer forces it low after a fixed run time.
module key_run_ctrl
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
    parameter int AUTO_OFF_CYCLES = 0,
    parameter int CNT_W           = 24,
    parameter int RUN_W           = 32
)(
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_pulse,
    output logic vaild
);

    localparam bit               AUTO_OFF_EN = (AUTO_OFF_CYCLES > 0);
    localparam logic [RUN_W-1:0] RUN_LAST    = AUTO_OFF_EN ? RUN_W'(AUTO_OFF_CYCLES - 1) : '0;

    logic             press_accept;
    logic             timeout;
    logic [RUN_W-1:0] run_cnt;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .key_n        (key_n),
        .key_level    (key_level),
        .key_pulse    (key_pulse),
        .press_accept (press_accept)
    );

    assign timeout = AUTO_OFF_EN && vaild && (run_cnt == RUN_LAST);

    // A press or timeout while running always stops; the run timer only counts while running.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            vaild   <= 1'b0;
            run_cnt <= '0;
        end else if (vaild && (timeout || press_accept)) begin
            vaild   <= 1'b0;
            run_cnt <= '0;
        end else if (press_accept) begin
            vaild   <= 1'b1;
            run_cnt <= '0;
        end else if (vaild && AUTO_OFF_EN) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end else begin
            run_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_key_run_ctrl.sv
// Bench for key_run_ctrl: two instances (auto-off disabled and 20 cycles) share
// the key and reset; a behavioural model fills a scoreboard checked every cycle.
module tb_key_run_ctrl;

    localparam int DEB  = 4;
    localparam int AUTO = 20;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic key_n   = 1'b1;

    logic key_level, key_pulse, vaild;
    logic ao_key_level, ao_key_pulse, ao_vaild;

    int n_checks    = 0;
    int n_fail      = 0;
    int pulse_total = 0;

    typedef struct {
        logic level;
        logic pulse;
        logic vaild;
        logic ao_vaild;
    } exp_t;

    exp_t sb_q[$];

    always #5 sys_clk = ~sys_clk;

    key_run_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .AUTO_OFF_CYCLES (0),
        .CNT_W           (24),
        .RUN_W           (32)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .key_level (key_level),
        .key_pulse (key_pulse),
        .vaild     (vaild)
    );

    key_run_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .AUTO_OFF_CYCLES (AUTO),
        .CNT_W           (24),
        .RUN_W           (32)
    ) dut_ao (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .key_level (ao_key_level),
        .key_pulse (ao_key_pulse),
        .vaild     (ao_vaild)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic key, input int cycles);
        key_n = key;
        repeat (cycles) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    // Behavioural model: the level flips after DEB+1 consecutive disagreeing samples.
    initial begin
        logic m_s1, m_s2, m_level, m_pulse, m_vaild, m_ao_vaild;
        logic press, pressed_s;
        int   m_run, m_hi;
        m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_pulse = 1'b0;
        m_vaild = 1'b0; m_ao_vaild = 1'b0; m_run = 0; m_hi = 0;
        forever begin
            @(posedge sys_clk);
            if (!rst_n) begin
                m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_pulse = 1'b0;
                m_vaild = 1'b0; m_ao_vaild = 1'b0; m_run = 0; m_hi = 0;
            end else begin
                pressed_s = ~m_s2;
                m_s2      = m_s1;
                m_s1      = key_n;
                m_pulse   = 1'b0;
                press     = 1'b0;
                if (pressed_s != m_level) m_run++;
                else m_run = 0;
                if (m_run == DEB + 1) begin
                    m_level = ~m_level;
                    m_run   = 0;
                    if (m_level) begin
                        m_pulse = 1'b1;
                        press   = 1'b1;
                    end
                end
                if (press) m_vaild = ~m_vaild;
                if (m_ao_vaild) begin
                    m_hi++;
                    if (press || m_hi == AUTO) begin
                        m_ao_vaild = 1'b0;
                        m_hi       = 0;
                    end
                end else if (press) begin
                    m_ao_vaild = 1'b1;
                    m_hi       = 0;
                end
            end
            sb_q.push_back('{m_level, m_pulse, m_vaild, m_ao_vaild});
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (key_pulse) pulse_total++;
            if (sb_q.size() == 0) begin
                check_output("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_output("sb_level",    {31'd0, key_level},    {31'd0, e.level});
                check_output("sb_pulse",    {31'd0, key_pulse},    {31'd0, e.pulse});
                check_output("sb_vaild",    {31'd0, vaild},        {31'd0, e.vaild});
                check_output("sb_ao_level", {31'd0, ao_key_level}, {31'd0, e.level});
                check_output("sb_ao_pulse", {31'd0, ao_key_pulse}, {31'd0, e.pulse});
                check_output("sb_ao_vaild", {31'd0, ao_vaild},     {31'd0, e.ao_vaild});
            end
        end
    end

    initial begin
        int p0;
        int p1;

        $display("[TB] reset with key toggling");
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(i[0], 1);
            check_output("rst_level", {31'd0, key_level}, 32'd0);
            check_output("rst_pulse", {31'd0, key_pulse}, 32'd0);
            check_output("rst_vaild", {31'd0, vaild},     32'd0);
        end
        rst_n = 1'b1;
        apply_stimulus(1'b1, 8);
        check_output("post_rst_level", {31'd0, key_level}, 32'd0);
        check_output("post_rst_vaild", {31'd0, vaild},     32'd0);

        $display("[TB] press bounce rejection");
        p0 = pulse_total;
        apply_stimulus(1'b0, 3);
        apply_stimulus(1'b1, 1);
        apply_stimulus(1'b0, 2);
        apply_stimulus(1'b1, 10);
        check_output("bounce_pulses", pulse_total - p0, 32'd0);
        check_output("bounce_vaild", {31'd0, vaild}, 32'd0);

        $display("[TB] clean press");
        p0 = pulse_total;
        apply_stimulus(1'b0, 6);
        check_output("pre_pulse", {31'd0, key_pulse}, 32'd0);
        check_output("pre_level", {31'd0, key_level}, 32'd0);
        check_output("pre_vaild", {31'd0, vaild},     32'd0);
        apply_stimulus(1'b0, 1);
        check_output("edge6_pulse", {31'd0, key_pulse}, 32'd1);
        check_output("edge6_level", {31'd0, key_level}, 32'd1);
        check_output("edge6_vaild", {31'd0, vaild},     32'd1);
        apply_stimulus(1'b0, 1);
        check_output("pulse_width", {31'd0, key_pulse}, 32'd0);
        check_output("hold_level",  {31'd0, key_level}, 32'd1);
        apply_stimulus(1'b0, 4);
        apply_stimulus(1'b1, 6);
        check_output("rel_hold_level", {31'd0, key_level}, 32'd1);
        apply_stimulus(1'b1, 1);
        check_output("rel_level", {31'd0, key_level}, 32'd0);
        check_output("rel_vaild", {31'd0, vaild},     32'd1);
        apply_stimulus(1'b1, 4);
        check_output("press_pulses", pulse_total - p0, 32'd1);

        $display("[TB] second press with release bounce");
        apply_stimulus(1'b0, 7);
        check_output("second_pulse", {31'd0, key_pulse}, 32'd1);
        check_output("second_vaild", {31'd0, vaild},     32'd0);
        apply_stimulus(1'b0, 3);
        apply_stimulus(1'b1, 2);
        apply_stimulus(1'b0, 6);
        apply_stimulus(1'b1, 10);
        check_output("total_pulses", pulse_total - p0, 32'd2);
        check_output("second_vaild_hold", {31'd0, vaild}, 32'd0);

        $display("[TB] auto-off");
        rst_n = 1'b0;
        apply_stimulus(1'b1, 2);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 4);
        p1 = pulse_total;
        apply_stimulus(1'b0, 6);
        check_output("ao_pre", {31'd0, ao_vaild}, 32'd0);
        apply_stimulus(1'b0, 1);
        check_output("ao_set", {31'd0, ao_vaild}, 32'd1);
        apply_stimulus(1'b0, 19);
        check_output("ao_last", {31'd0, ao_vaild}, 32'd1);
        apply_stimulus(1'b0, 1);
        check_output("ao_timeout", {31'd0, ao_vaild}, 32'd0);
        check_output("ao_main_vaild", {31'd0, vaild}, 32'd1);
        apply_stimulus(1'b0, 10);
        check_output("ao_held", {31'd0, ao_vaild}, 32'd0);
        check_output("ao_held_pulses", pulse_total - p1, 32'd1);
        apply_stimulus(1'b1, 10);

        $display("[TB] reset mid-debounce");
        p0 = pulse_total;
        apply_stimulus(1'b0, 4);
        rst_n = 1'b0;
        #1;
        check_output("async_rst_level", {31'd0, key_level}, 32'd0);
        check_output("async_rst_vaild", {31'd0, vaild},     32'd0);
        check_output("async_rst_ao",    {31'd0, ao_vaild},  32'd0);
        apply_stimulus(1'b0, 2);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 6);
        check_output("rst_mid_nopulse", pulse_total - p0, 32'd0);
        check_output("rst_mid_vaild0", {31'd0, vaild}, 32'd0);
        apply_stimulus(1'b0, 1);
        check_output("rst_mid_pulse", {31'd0, key_pulse}, 32'd1);
        check_output("rst_mid_vaild1", {31'd0, vaild},    32'd1);
        apply_stimulus(1'b1, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
